// File: rtl/day_time_sequencer.sv
// Day-time traffic light sequencer: serves four approach pairs round-robin,
// skipping pairs without demand. Each green is bounded by a minimum, a
// maximum (only enforced when another pair waits) and is followed by an
// all-red clearance.
//
// state | meaning
// IDLE  | all red, waiting for day mode with demand
// GREEN | served pair (phase) shows go, cnt counts green cycles
// CLEAR | all red clearance between greens, cnt counts clearance cycles
module day_time_sequencer #(
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 10,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] demand,
    output logic [7:0] lightOut,
    output logic [1:0] phase,
    output logic       clearing
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GREEN = 2'd1,
        CLEAR = 2'd2
    } stateT;

    // Exit thresholds compare against cnt, which equals (cycles spent - 1).
    localparam logic [7:0] MIN_LAST   = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_LAST   = 8'(MAX_GREEN - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);

    stateT      state;
    stateT      stateNext;
    logic [7:0] cnt;
    logic [7:0] cntNext;
    logic [7:0] cntInc;
    logic [7:0] lightNext;
    logic [1:0] phaseNext;
    logic       clearingNext;
    logic [3:0] pairDemand;
    logic       anyDemand;
    logic       otherDemand;
    logic [1:0] selPair;
    logic       selValid;

    // P0 sits in the top two bits, P3 in the bottom two.
    assign pairDemand[0] = demand[7] | demand[6];
    assign pairDemand[1] = demand[5] | demand[4];
    assign pairDemand[2] = demand[3] | demand[2];
    assign pairDemand[3] = demand[1] | demand[0];
    assign anyDemand     = |demand;
    assign otherDemand   = |(pairDemand & ~(4'b0001 << phase));
    assign cntInc        = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // Round-robin pick starting after the current pair; the current pair is
    // searched last so it only wins when it is the sole demanding pair.
    always_comb begin
        selValid = 1'b0;
        selPair  = phase;
        for (int i = 1; i <= 4; i++) begin
            if (!selValid && pairDemand[phase + 2'(i)]) begin
                selValid = 1'b1;
                selPair  = phase + 2'(i);
            end
        end
    end

    // Next-state and next-output decode; outputs are registered with state.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        lightNext    = 8'h00;
        phaseNext    = phase;
        clearingNext = 1'b0;
        case (state)
            IDLE: begin
                if (en && anyDemand && selValid) begin
                    stateNext = GREEN;
                    phaseNext = selPair;
                    cntNext   = 8'd0;
                    lightNext = 8'hC0 >> {selPair, 1'b0};
                end
            end
            GREEN: begin
                if (!en
                    || (cnt >= MIN_LAST && !pairDemand[phase])
                    || (cnt >= MAX_LAST && otherDemand)) begin
                    stateNext    = CLEAR;
                    cntNext      = 8'd0;
                    clearingNext = 1'b1;
                end else begin
                    cntNext   = cntInc;
                    lightNext = 8'hC0 >> {phase, 1'b0};
                end
            end
            CLEAR: begin
                if (cnt >= CLEAR_LAST) begin
                    if (en && anyDemand && selValid) begin
                        stateNext = GREEN;
                        phaseNext = selPair;
                        cntNext   = 8'd0;
                        lightNext = 8'hC0 >> {selPair, 1'b0};
                    end else begin
                        stateNext = IDLE;
                        cntNext   = 8'd0;
                    end
                end else begin
                    cntNext      = cntInc;
                    clearingNext = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 8'd0;
            end
        endcase
    end

    // State and output registers; reset forces all red immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            lightOut <= 8'h00;
            phase    <= 2'd3;
            clearing <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            lightOut <= lightNext;
            phase    <= phaseNext;
            clearing <= clearingNext;
        end
    end

endmodule

// File: tb/tb_day_time_sequencer.sv
// Directed bench for day_time_sequencer with hand-computed expectations
// (MIN_GREEN=4, MAX_GREEN=10, CLEAR_CYCLES=2).
module tb_day_time_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] demand;
    logic [7:0] lightOut;
    logic [1:0] phase;
    logic       clearing;

    int total = 0;
    int bad   = 0;

    day_time_sequencer #(
        .MIN_GREEN   (4),
        .MAX_GREEN   (10),
        .CLEAR_CYCLES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .demand  (demand),
        .lightOut(lightOut),
        .phase   (phase),
        .clearing(clearing)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst    = 1'b0;
        en     = 1'b0;
        demand = 8'h00;
        tick();
        rst = 1'b1;
    endtask

    // Light vector must only ever show one whole pair.
    always @(negedge clk) begin
        if (rst) begin
            checkEq("pairShape",
                    8'((lightOut inside {8'h00, 8'hC0, 8'h30, 8'h0C, 8'h03}) ? 1 : 0), 8'd1);
        end
    end

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        demand = 8'hFF;

        // Reset holds everything idle even with demand.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("rstLight", lightOut, 8'h00);
            checkEq("rstClear", 8'(clearing), 8'h00);
            checkEq("rstPhase", 8'(phase), 8'h03);
        end
        rst = 1'b1;
        tick();
        checkEq("firstLight", lightOut, 8'hC0);
        checkEq("firstPhase", 8'(phase), 8'h00);

        // Round-robin between P1 and P3, P0/P2 skipped.
        resetDut();
        en     = 1'b1;
        demand = 8'h33;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("rrP1", lightOut, 8'h30);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checkEq("rrClrA", lightOut, 8'h00);
            checkEq("rrClrAflag", 8'(clearing), 8'h01);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("rrP3", lightOut, 8'h03);
            checkEq("rrP3phase", 8'(phase), 8'h03);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checkEq("rrClrB", 8'(clearing), 8'h01);
        end
        tick();
        checkEq("rrBackP1", lightOut, 8'h30);

        // Early termination at MIN_GREEN once demand disappears.
        resetDut();
        en     = 1'b1;
        demand = 8'h08;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkEq("earlyGreen", lightOut, 8'h0C);
            if (i == 1) demand = 8'h00;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checkEq("earlyClrLight", lightOut, 8'h00);
            checkEq("earlyClr", 8'(clearing), 8'h01);
        end
        tick();
        checkEq("earlyIdleLight", lightOut, 8'h00);
        checkEq("earlyIdleClr", 8'(clearing), 8'h00);

        // Rest in green, then extension ends when another pair asks.
        resetDut();
        en     = 1'b1;
        demand = 8'h40;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkEq("restP0", lightOut, 8'hC0);
        end
        demand = 8'h41;
        tick();
        checkEq("restExit", 8'(clearing), 8'h01);
        checkEq("restExitLight", lightOut, 8'h00);
        tick();
        checkEq("restClr2", 8'(clearing), 8'h01);
        // P3 now runs to MAX_GREEN because P0 is waiting.
        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("extP3", lightOut, 8'h03);
        end
        tick();
        checkEq("extMaxExit", 8'(clearing), 8'h01);
        tick();
        tick();
        checkEq("extBackP0", lightOut, 8'hC0);

        // Dropping en mid-green cuts the green and then idles.
        resetDut();
        en     = 1'b1;
        demand = 8'hFF;
        tick();
        checkEq("enG0", lightOut, 8'hC0);
        tick();
        checkEq("enG1", lightOut, 8'hC0);
        en = 1'b0;
        tick();
        checkEq("enDropLight", lightOut, 8'h00);
        checkEq("enDropClr", 8'(clearing), 8'h01);
        tick();
        checkEq("enDropClr2", 8'(clearing), 8'h01);
        tick();
        checkEq("enIdleLight", lightOut, 8'h00);
        checkEq("enIdleClr", 8'(clearing), 8'h00);
        tick();
        checkEq("enStayIdle", lightOut, 8'h00);

        // Asynchronous reset in the middle of a P1 green.
        resetDut();
        en     = 1'b1;
        demand = 8'h30;
        tick();
        checkEq("asyncP1", lightOut, 8'h30);
        checkEq("asyncP1phase", 8'(phase), 8'h01);
        tick();
        #2;
        rst = 1'b0;
        #1;
        checkEq("asyncLight", lightOut, 8'h00);
        checkEq("asyncPhase", 8'(phase), 8'h03);
        demand = 8'hFF;
        tick();
        checkEq("asyncHeld", lightOut, 8'h00);
        rst = 1'b1;
        tick();
        checkEq("asyncRestart", lightOut, 8'hC0);
        checkEq("asyncRestartPh", 8'(phase), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
